// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   state_t     : arbiter sequencing states
//   grant_t     : which requester owns the memory port
//   POISON_WORD : fill pattern returned to a requester whose read timed out
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        RESP
    } state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

    localparam logic [31:0] POISON_WORD = 32'hdeadbeef;

    // Terminal count of the 16-bit wait counter for a given timeout length.
    function automatic logic [15:0] wait_last(input int cycles);
        return 16'(cycles - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache-side and memory-side signals of the memory port arbiter.
//   slave  : arbiter view (takes cache strobes and memory completions)
//   master : environment view (cache controllers plus memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    logic                  strobe_icache_i;
    logic [ADDR_WIDTH-1:0] addr_icache_i;
    logic [DATA_WIDTH-1:0] rdata_icache_o;
    logic                  done_icache_o;

    logic                  strobe_dcache_i;
    logic [ADDR_WIDTH-1:0] addr_dcache_i;
    logic [DATA_WIDTH-1:0] wdata_dcache_i;
    logic                  rw_dcache_i;
    logic [DATA_WIDTH-1:0] rdata_dcache_o;
    logic                  done_dcache_o;

    logic                  mem_strobe_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_rw_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_done_i;

    logic                  proto_err_o;
    logic                  timeout_err_o;

    modport slave (
        input  strobe_icache_i, addr_icache_i,
        input  strobe_dcache_i, addr_dcache_i, wdata_dcache_i, rw_dcache_i,
        input  mem_rdata_i, mem_done_i,
        output rdata_icache_o, done_icache_o,
        output rdata_dcache_o, done_dcache_o,
        output mem_strobe_o, mem_addr_o, mem_wdata_o, mem_rw_o,
        output proto_err_o, timeout_err_o
    );

    modport master (
        output strobe_icache_i, addr_icache_i,
        output strobe_dcache_i, addr_dcache_i, wdata_dcache_i, rw_dcache_i,
        output mem_rdata_i, mem_done_i,
        input  rdata_icache_o, done_icache_o,
        input  rdata_dcache_o, done_dcache_o,
        input  mem_strobe_o, mem_addr_o, mem_wdata_o, mem_rw_o,
        input  proto_err_o, timeout_err_o
    );

endinterface

// File: rtl/mem_port_arbiter_req_slot.sv
// One requester's request slot: pending flag, latched request and
// sticky protocol-error detect.
//   strobe_i/addr_i/wdata_i/rw_i : request pulse and its payload
//   clear_i                      : request served, drop pending
//   pend_o/addr_o/wdata_o/rw_o   : latched request
//   proto_err_o                  : sticky, strobe seen while already pending
module mem_arb_req_slot #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rw_i,
    input  logic                  clear_i,
    output logic                  pend_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  rw_o,
    output logic                  proto_err_o
);

    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rw_q, rw_d;
    logic                  proto_err_q, proto_err_d;

    // The check uses pend_q, so a strobe in the cycle the slot is being
    // cleared still sees it pending and is dropped as an error.
    always_comb begin
        pend_d      = pend_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        proto_err_d = proto_err_q;
        if (clear_i) begin
            pend_d = 1'b0;
        end
        if (strobe_i) begin
            if (pend_q) begin
                proto_err_d = 1'b1;
            end else begin
                pend_d  = 1'b1;
                addr_d  = addr_i;
                wdata_d = wdata_i;
                rw_d    = rw_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign pend_o      = pend_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign rw_o        = rw_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the icache refill
// path and the dcache refill/writeback path, one transaction at a time,
// with a watchdog on the memory wait.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : cache request/response signals and the memory port
//
//   state | meaning
//   IDLE  | waiting for a pending request, picks the grant
//   ISSUE | mem_strobe_o high for one cycle, wait counter cleared
//   WAIT  | waiting for mem_done_i or watchdog expiry
//   RESP  | done pulse to the granted requester, its slot cleared
//   DRAIN | after a timeout, swallow the late mem_done_i before reuse
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit DCACHE_FIRST   = 1'b1
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [15:0]           WAIT_LAST   = wait_last(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] POISON_LINE = {(DATA_WIDTH / 32){POISON_WORD}};
    // last_grant after reset is the loser of the first tie.
    localparam grant_t                GRANT_RST   = DCACHE_FIRST ? GNT_I : GNT_D;

    logic                  pend_icache, pend_dcache;
    logic [ADDR_WIDTH-1:0] req_addr_icache, req_addr_dcache;
    logic [DATA_WIDTH-1:0] req_wdata_icache, req_wdata_dcache;
    logic                  req_rw_icache, req_rw_dcache;
    logic                  perr_icache, perr_dcache;
    logic                  clear_icache, clear_dcache;

    state_t                state_q, state_d;
    grant_t                gnt_q, gnt_d;
    grant_t                last_grant_q, last_grant_d;
    grant_t                pick;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic                  aborted_q, aborted_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  mem_strobe_q, mem_strobe_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [DATA_WIDTH-1:0] rdata_icache_q, rdata_icache_d;
    logic [DATA_WIDTH-1:0] rdata_dcache_q, rdata_dcache_d;
    logic                  done_icache_q, done_icache_d;
    logic                  done_dcache_q, done_dcache_d;

    assign clear_icache = (state_q == RESP) && (gnt_q == GNT_I);
    assign clear_dcache = (state_q == RESP) && (gnt_q == GNT_D);

    // The icache path never writes, so its slot stores constant zeros and
    // the memory side sees rw=0/wdata=0 for icache grants.
    mem_arb_req_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_icache (
        .clk         (clk),
        .rst         (rst),
        .strobe_i    (bus.strobe_icache_i),
        .addr_i      (bus.addr_icache_i),
        .wdata_i     ({DATA_WIDTH{1'b0}}),
        .rw_i        (1'b0),
        .clear_i     (clear_icache),
        .pend_o      (pend_icache),
        .addr_o      (req_addr_icache),
        .wdata_o     (req_wdata_icache),
        .rw_o        (req_rw_icache),
        .proto_err_o (perr_icache)
    );

    mem_arb_req_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_dcache (
        .clk         (clk),
        .rst         (rst),
        .strobe_i    (bus.strobe_dcache_i),
        .addr_i      (bus.addr_dcache_i),
        .wdata_i     (bus.wdata_dcache_i),
        .rw_i        (bus.rw_dcache_i),
        .clear_i     (clear_dcache),
        .pend_o      (pend_dcache),
        .addr_o      (req_addr_dcache),
        .wdata_o     (req_wdata_dcache),
        .rw_o        (req_rw_dcache),
        .proto_err_o (perr_dcache)
    );

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_grant_d   = last_grant_q;
        wait_cnt_d     = wait_cnt_q;
        aborted_d      = aborted_q;
        timeout_err_d  = timeout_err_q;
        mem_strobe_d   = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_rw_d       = mem_rw_q;
        rdata_icache_d = rdata_icache_q;
        rdata_dcache_d = rdata_dcache_q;
        done_icache_d  = 1'b0;
        done_dcache_d  = 1'b0;
        pick           = pend_icache ? GNT_I : GNT_D;

        unique case (state_q)
            IDLE: begin
                if (pend_icache || pend_dcache) begin
                    if (pend_icache && pend_dcache) begin
                        pick         = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
                        last_grant_d = pick;
                    end
                    gnt_d        = pick;
                    mem_strobe_d = 1'b1;
                    if (pick == GNT_I) begin
                        mem_addr_d  = req_addr_icache;
                        mem_wdata_d = req_wdata_icache;
                        mem_rw_d    = req_rw_icache;
                    end else begin
                        mem_addr_d  = req_addr_dcache;
                        mem_wdata_d = req_wdata_dcache;
                        mem_rw_d    = req_rw_dcache;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (bus.mem_done_i || (wait_cnt_q == WAIT_LAST)) begin
                    if (!mem_rw_q) begin
                        if (gnt_q == GNT_I) begin
                            rdata_icache_d = bus.mem_done_i ? bus.mem_rdata_i : POISON_LINE;
                        end else begin
                            rdata_dcache_d = bus.mem_done_i ? bus.mem_rdata_i : POISON_LINE;
                        end
                    end
                    if (!bus.mem_done_i) begin
                        timeout_err_d = 1'b1;
                        aborted_d     = 1'b1;
                    end
                    done_icache_d = (gnt_q == GNT_I);
                    done_dcache_d = (gnt_q == GNT_D);
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = aborted_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (bus.mem_done_i) begin
                    aborted_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            gnt_q          <= GNT_I;
            last_grant_q   <= GRANT_RST;
            wait_cnt_q     <= '0;
            aborted_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            mem_strobe_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_rw_q       <= 1'b0;
            rdata_icache_q <= '0;
            rdata_dcache_q <= '0;
            done_icache_q  <= 1'b0;
            done_dcache_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            last_grant_q   <= last_grant_d;
            wait_cnt_q     <= wait_cnt_d;
            aborted_q      <= aborted_d;
            timeout_err_q  <= timeout_err_d;
            mem_strobe_q   <= mem_strobe_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_rw_q       <= mem_rw_d;
            rdata_icache_q <= rdata_icache_d;
            rdata_dcache_q <= rdata_dcache_d;
            done_icache_q  <= done_icache_d;
            done_dcache_q  <= done_dcache_d;
        end
    end

    assign bus.rdata_icache_o = rdata_icache_q;
    assign bus.done_icache_o  = done_icache_q;
    assign bus.rdata_dcache_o = rdata_dcache_q;
    assign bus.done_dcache_o  = done_dcache_q;
    assign bus.mem_strobe_o   = mem_strobe_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_wdata_o    = mem_wdata_q;
    assign bus.mem_rw_o       = mem_rw_q;
    assign bus.proto_err_o    = perr_icache | perr_dcache;
    assign bus.timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected
// completions per requester, a negedge monitor pops and compares on every
// done pulse, and a behavioural memory answers the port.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int TO = 8;
    localparam logic [DW-1:0] POISON = {8{32'hdeadbeef}};

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rw;
        logic [DW-1:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .DCACHE_FIRST   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail = 0;
    txn_t iq[$];
    txn_t dq[$];
    txn_t mem_log[$];
    int   done_order[$];
    int   n_mem_issue = 0;
    int   n_done_d = 0;
    int   last_strobe_cyc = -1;
    int   last_done_i_cyc = -1;
    int   last_done_d_cyc = -1;
    logic [DW-1:0] last_d_rdata = '0;
    logic [DW-1:0] mem_store [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit   mem_auto = 1'b1;
    bit   rand_delay = 1'b0;
    bit   man_pulse = 1'b0;
    int   mem_delay = 3;

    function automatic logic [DW-1:0] gen_line(input logic [AW-1:0] a);
        logic [DW-1:0] l;
        for (int i = 0; i < DW / 32; i++) begin
            l[i*32 +: 32] = a ^ (32'(i) * 32'h1111_1111) ^ 32'h5a5a_0000;
        end
        return l;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] l;
        for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no completion expected completion", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push_i(input logic [AW-1:0] a, input bit poison);
        txn_t t;
        t.addr  = a;
        t.wdata = '0;
        t.rw    = 1'b0;
        t.rdata = poison ? POISON : gen_line(a);
        iq.push_back(t);
    endtask

    task automatic push_d(input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit rw, input bit poison);
        txn_t t;
        t.addr  = a;
        t.wdata = wd;
        t.rw    = rw;
        if (rw) begin
            ref_mem[a] = wd;
            t.rdata    = last_d_rdata;
        end else begin
            t.rdata = poison ? POISON : (ref_mem.exists(a) ? ref_mem[a] : gen_line(a));
            last_d_rdata = t.rdata;
        end
        dq.push_back(t);
    endtask

    // One-cycle strobe(s) in the current cycle; only the flagged side is touched.
    task automatic fire(input bit si, input logic [AW-1:0] ai, input bit sd,
                        input logic [AW-1:0] ad, input logic [DW-1:0] wd, input bit rw);
        if (si) begin
            bus.strobe_icache_i = 1'b1;
            bus.addr_icache_i   = ai;
        end
        if (sd) begin
            bus.strobe_dcache_i = 1'b1;
            bus.addr_dcache_i   = ad;
            bus.wdata_dcache_i  = wd;
            bus.rw_dcache_i     = rw;
        end
        tick();
        if (si) bus.strobe_icache_i = 1'b0;
        if (sd) bus.strobe_dcache_i = 1'b0;
    endtask

    task automatic wait_q(input int id, input int budget);
        int n = 0;
        while (((id == 0) ? iq.size() : dq.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        if (((id == 0) ? iq.size() : dq.size()) != 0) begin
            fail_msg((id == 0) ? "wait_icache_done" : "wait_dcache_done");
        end
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_rdata_icache"}, bus.rdata_icache_o, '0);
        check({tag, "_rdata_dcache"}, bus.rdata_dcache_o, '0);
        check({tag, "_done_icache"}, DW'(bus.done_icache_o), '0);
        check({tag, "_done_dcache"}, DW'(bus.done_dcache_o), '0);
        check({tag, "_mem_strobe"}, DW'(bus.mem_strobe_o), '0);
        check({tag, "_mem_addr"}, DW'(bus.mem_addr_o), '0);
        check({tag, "_mem_wdata"}, bus.mem_wdata_o, '0);
        check({tag, "_mem_rw"}, DW'(bus.mem_rw_o), '0);
        check({tag, "_proto_err"}, DW'(bus.proto_err_o), '0);
        check({tag, "_timeout_err"}, DW'(bus.timeout_err_o), '0);
    endtask

    task automatic complete(input int id);
        txn_t e;
        txn_t m;
        string nm;
        logic [DW-1:0] act;
        nm = (id == 0) ? "icache" : "dcache";
        if (id == 0) begin
            last_done_i_cyc = cyc;
            if (iq.size() == 0) begin
                fail_msg("unexpected_done_icache");
                return;
            end
            e   = iq.pop_front();
            act = bus.rdata_icache_o;
        end else begin
            n_done_d++;
            last_done_d_cyc = cyc;
            if (dq.size() == 0) begin
                fail_msg("unexpected_done_dcache");
                return;
            end
            e   = dq.pop_front();
            act = bus.rdata_dcache_o;
        end
        done_order.push_back(id);
        if (mem_log.size() == 0) begin
            fail_msg({"mem_issue_", nm});
        end else begin
            m = mem_log.pop_front();
            check({"mem_addr_", nm}, DW'(m.addr), DW'(e.addr));
            check({"mem_rw_", nm}, DW'(m.rw), DW'(e.rw));
            check({"mem_wdata_", nm}, m.wdata, e.wdata);
        end
        check({"rdata_", nm}, act, e.rdata);
    endtask

    // Monitor: records memory issues, checks completions against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_strobe_o) begin
                mem_log.push_back('{bus.mem_addr_o, bus.mem_wdata_o, bus.mem_rw_o, '0});
                n_mem_issue++;
                last_strobe_cyc = cyc;
            end
            if (bus.done_icache_o && bus.done_dcache_o) begin
                check("done_exclusive", DW'(1), DW'(0));
            end
            if (bus.done_icache_o) complete(0);
            if (bus.done_dcache_o) complete(1);
        end
    end

    // Memory model: answers D cycles after the strobe, or emits one stray
    // done on request (used to release the arbiter from DRAIN).
    initial begin
        int d;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic rw;
        bus.mem_done_i  = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (man_pulse) begin
                man_pulse = 1'b0;
                @(posedge clk);
                #1;
                bus.mem_rdata_i = {8{32'h0badf00d}};
                bus.mem_done_i  = 1'b1;
                @(posedge clk);
                #1;
                bus.mem_done_i = 1'b0;
            end else if (mem_auto && !rst && bus.mem_strobe_o) begin
                a  = bus.mem_addr_o;
                wd = bus.mem_wdata_o;
                rw = bus.mem_rw_o;
                d  = rand_delay ? int'($urandom_range(1, 5)) : mem_delay;
                repeat (d) @(posedge clk);
                #1;
                if (rw) begin
                    mem_store[a]    = wd;
                    bus.mem_rdata_i = rand_line();
                end else begin
                    bus.mem_rdata_i = mem_store.exists(a) ? mem_store[a] : gen_line(a);
                end
                bus.mem_done_i = 1'b1;
                @(posedge clk);
                #1;
                bus.mem_done_i = 1'b0;
            end
        end
    end

    initial begin
        int t0;
        int ni;
        int nd;
        logic [DW-1:0] pat;
        bus.strobe_icache_i = 1'b0;
        bus.addr_icache_i   = '0;
        bus.strobe_dcache_i = 1'b0;
        bus.addr_dcache_i   = '0;
        bus.wdata_dcache_i  = '0;
        bus.rw_dcache_i     = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Single icache read with fixed latency.
        mem_delay  = 3;
        rand_delay = 1'b0;
        nd = n_done_d;
        push_i(32'h8000_0040, 1'b0);
        t0 = cyc;
        fire(1'b1, 32'h8000_0040, 1'b0, '0, '0, 1'b0);
        wait_q(0, 100);
        check("single_strobe_cycle", DW'(last_strobe_cyc), DW'(t0 + 2));
        check("single_done_cycle", DW'(last_done_i_cyc), DW'(t0 + 6));
        check("single_no_dcache_done", DW'(n_done_d), DW'(nd));

        // Simultaneous strobes: dcache first after reset, then alternate.
        rand_delay = 1'b1;
        for (int round = 0; round < 2; round++) begin
            done_order.delete();
            push_i(32'h4000_0080 + 32'(round * 32), 1'b0);
            push_d(32'h9000_0040 + 32'(round * 32), '0, 1'b0, 1'b0);
            fire(1'b1, 32'h4000_0080 + 32'(round * 32), 1'b1, 32'h9000_0040 + 32'(round * 32), '0, 1'b0);
            wait_q(0, 100);
            wait_q(1, 100);
            check("rr_count", DW'(done_order.size()), DW'(2));
            if (done_order.size() >= 2) begin
                check("rr_first", DW'(done_order[0]), (round == 0) ? DW'(1) : DW'(0));
                check("rr_second", DW'(done_order[1]), (round == 0) ? DW'(0) : DW'(1));
            end
        end

        // dcache write with byte pattern 01..20, then read it back.
        for (int b = 0; b < 32; b++) pat[DW-1-8*b -: 8] = 8'(b + 1);
        push_d(32'h8000_0100, pat, 1'b1, 1'b0);
        fire(1'b0, '0, 1'b1, 32'h8000_0100, pat, 1'b1);
        wait_q(1, 100);
        check("write_rdata_unchanged", bus.rdata_dcache_o, last_d_rdata);
        push_d(32'h8000_0100, '0, 1'b0, 1'b0);
        fire(1'b0, '0, 1'b1, 32'h8000_0100, '0, 1'b0);
        wait_q(1, 100);

        // Second icache strobe while pending: dropped, sticky error.
        check("proto_err_clean", DW'(bus.proto_err_o), DW'(0));
        ni = n_mem_issue;
        push_i(32'h4000_0100, 1'b0);
        fire(1'b1, 32'h4000_0100, 1'b0, '0, '0, 1'b0);
        fire(1'b1, 32'h4000_0200, 1'b0, '0, '0, 1'b0);
        wait_q(0, 100);
        repeat (5) tick();
        check("proto_single_issue", DW'(n_mem_issue), DW'(ni + 1));
        check("proto_err_set", DW'(bus.proto_err_o), DW'(1));

        // Timeout on a dcache read with an icache request queued behind it.
        mem_auto = 1'b0;
        ni = n_mem_issue;
        push_d(32'h9000_0080, '0, 1'b0, 1'b1);
        t0 = cyc;
        fire(1'b0, '0, 1'b1, 32'h9000_0080, '0, 1'b0);
        push_i(32'h4000_0300, 1'b0);
        fire(1'b1, 32'h4000_0300, 1'b0, '0, '0, 1'b0);
        wait_q(1, 60);
        check("timeout_done_cycle", DW'(last_done_d_cyc), DW'(t0 + 11));
        check("timeout_err_set", DW'(bus.timeout_err_o), DW'(1));
        repeat (20) tick();
        check("drain_blocks_issue", DW'(n_mem_issue), DW'(ni + 1));
        check("drain_icache_waiting", DW'(iq.size()), DW'(1));
        rand_delay = 1'b0;
        mem_delay  = 2;
        mem_auto   = 1'b1;
        man_pulse  = 1'b1;
        wait_q(0, 60);
        check("drain_then_issue", DW'(n_mem_issue), DW'(ni + 2));
        check("drain_data_discarded", bus.rdata_dcache_o, POISON);
        check("proto_err_sticky", DW'(bus.proto_err_o), DW'(1));

        // Asynchronous reset in the middle of WAIT.
        mem_auto = 1'b0;
        push_i(32'h4000_0400, 1'b0);
        fire(1'b1, 32'h4000_0400, 1'b0, '0, '0, 1'b0);
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        outputs_zero("midrst");
        iq.delete();
        dq.delete();
        mem_log.delete();
        last_d_rdata = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_auto = 1'b1;
        mem_delay = 3;
        tick();

        // Fresh transaction after reset, then a strobe in its RESP cycle.
        ni = n_mem_issue;
        push_i(32'h4000_0500, 1'b0);
        t0 = cyc;
        fire(1'b1, 32'h4000_0500, 1'b0, '0, '0, 1'b0);
        go_to(t0 + 6);
        fire(1'b1, 32'h4000_0600, 1'b0, '0, '0, 1'b0);
        repeat (10) tick();
        check("postrst_strobe_cycle", DW'(last_strobe_cyc), DW'(t0 + 2));
        check("postrst_done_cycle", DW'(last_done_i_cyc), DW'(t0 + 6));
        check("resp_strobe_dropped", DW'(n_mem_issue), DW'(ni + 1));
        check("resp_strobe_err", DW'(bus.proto_err_o), DW'(1));
        check("resp_queue_empty", DW'(iq.size()), DW'(0));

        // Randomized concurrent traffic from both requesters.
        rand_delay = 1'b1;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    logic [AW-1:0] a;
                    repeat ($urandom_range(0, 3)) tick();
                    a = 32'h4000_0000 + (32'($urandom_range(0, 255)) << 5);
                    push_i(a, 1'b0);
                    fire(1'b1, a, 1'b0, '0, '0, 1'b0);
                    wait_q(0, 200);
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    logic [AW-1:0] a;
                    logic [DW-1:0] wd;
                    bit rw;
                    repeat ($urandom_range(0, 3)) tick();
                    a  = 32'h9000_0000 + (32'($urandom_range(0, 7)) << 5);
                    wd = rand_line();
                    rw = 1'($urandom_range(0, 1));
                    push_d(a, wd, rw, 1'b0);
                    fire(1'b0, '0, 1'b1, a, wd, rw);
                    wait_q(1, 200);
                end
            end
        join
        repeat (10) tick();
        check("final_timeout_err_clear", DW'(bus.timeout_err_o), DW'(0));
        check("final_proto_err_sticky", DW'(bus.proto_err_o), DW'(1));
        check("final_mem_log_empty", DW'(mem_log.size()), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port (strobe/addr/wdata/rw/rdata/done, same protocol as the team's simulation RAM port) between the icache refill path and the dcache refill/writeback path.
- Latches one request per requester and grants round-robin, one transaction at a time.
- Returns data and a one-cycle done pulse to the granted requester.
- A watchdog bounds wait time on the memory side.
- Sits between the cache controllers and the memory model or memory controller.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 256, cache-line width; must be a multiple of 32
TIMEOUT_CYCLES, 1024, WAIT cycles before a transaction is aborted (16-bit counter; legal range 1..65535)
DCACHE_FIRST, 1, 1: dcache wins the first tie after reset; 0: icache wins

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
strobe_icache_i  in  1  icache request pulse
addr_icache_i  in  ADDR_WIDTH  icache line address
rdata_icache_o  out  DATA_WIDTH  icache read line
done_icache_o  out  1  icache completion pulse
strobe_dcache_i  in  1  dcache request pulse
addr_dcache_i  in  ADDR_WIDTH  dcache line address
wdata_dcache_i  in  DATA_WIDTH  dcache write line
rw_dcache_i  in  1  1 = write, 0 = read
rdata_dcache_o  out  DATA_WIDTH  dcache read line
done_dcache_o  out  1  dcache completion pulse
mem_strobe_o  out  1  memory request, one-cycle pulse
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rw_o  out  1  memory direction
mem_rdata_i  in  DATA_WIDTH  memory read data
mem_done_i  in  1  memory completion
proto_err_o  out  1  sticky: strobe received while that requester was pending
timeout_err_o  out  1  sticky: a transaction timed out

Behaviour:
- Reset (async, any state): state=IDLE; both pending flags=0; all outputs=0 (rdata regs, done, mem_*, error flags); wait counter=0; last_grant=icache if DCACHE_FIRST else dcache.
- Capture: strobe_x_i=1 with pend_x=0 sets pend_x next cycle and latches addr (plus wdata/rw for dcache) into that requester's request register.
- strobe_x_i=1 with pend_x=1 is ignored and sets proto_err_o.
- pend_x clears in the RESP cycle for x. A strobe in that same cycle counts as pending, so it is an error and is dropped.
- IDLE: if any pend, grant and go ISSUE.
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant; update last_grant.
- ISSUE (1 cycle): mem_strobe_o=1; mem_addr/wdata/rw driven from the granted request register. The icache grant always drives rw=0 and wdata=0. Clear the wait counter. Go WAIT.
- mem_addr/wdata/rw hold their values from ISSUE through WAIT and DRAIN. They are don't-care elsewhere but must not glitch during WAIT.
- WAIT:
  - mem_done_i=1: capture mem_rdata_i into the granted requester's rdata reg (read only; writes leave rdata unchanged); go RESP.
  - else, if counter == TIMEOUT_CYCLES-1: load rdata reg (read only) with 32'hdeadbeef replicated DATA_WIDTH/32 times; set timeout_err_o and an internal aborted flag; go RESP.
  - else counter+1.
- RESP (1 cycle): done_x_o=1 for the granted requester only; clear pend_x. If aborted, go DRAIN, else IDLE.
- DRAIN: wait for mem_done_i, discard the data, clear aborted, go IDLE. Takes no new grants. Only reset exits DRAIN without mem_done_i.
- mem_done_i outside WAIT/DRAIN is ignored.
- rdata_x_o holds its value until that requester's next read completes.
- Latency (idle arbiter, strobe in cycle T, memory done in cycle T+2+D with D≥1):
  - T+1: grant.
  - T+2: mem_strobe_o.
  - T+3+D: done_x_o and rdata valid.
- Back-to-back: a second pending requester gets mem_strobe_o at T+5+D.
- Simultaneous strobes in the same cycle: both are captured and served in round-robin order.
- Reset mid-transaction also clears outstanding state. Memory must be reset in the same cycle.

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, ISSUE, WAIT, DRAIN, RESP}; grant_t {GNT_I, GNT_D}; POISON_WORD=32'hdeadbeef.
- One sub-module, mem_arb_req_slot: pending flag, request register, and proto_err detect, instantiated twice (the icache copy ties wdata/rw to 0).

Test Plan:
- Single icache read, memory model D=3, addr 0x80000040: mem_strobe_o at T+2 with addr 0x80000040 and rw=0; done_icache_o=1 only at T+6; rdata_icache_o equals model data; done_dcache_o stays 0.
- Simultaneous icache and dcache strobes after reset, DCACHE_FIRST=1: dcache transaction is issued first, icache second. Repeat with both strobing again: icache is served first this time (alternation).
- dcache write, addr 0x80000100, wdata pattern 0x0102..20, rw=1: mem_rw_o=1, mem_wdata_o matches the pattern, done_dcache_o pulses once, rdata_dcache_o unchanged.
- Second icache strobe while icache is pending: no extra transaction; proto_err_o=1 and stays 1 until rst.
- TIMEOUT_CYCLES=8, memory never asserts done: done_dcache_o after 8 WAIT cycles, rdata all 0xdeadbeef words, timeout_err_o=1. A pending icache request is not issued until mem_done_i is later asserted in DRAIN.
- rst asserted asynchronously mid-WAIT: all outputs 0 immediately and state IDLE; a new strobe after rst deassertion completes normally.
